// File: rtl/iter_mdu_if.sv
// -----------------------------------------------------------------------------
// iter_mdu_if
// Bundle of handshake and data signals between the integer execute stage and
// the iterative multiply/divide unit.
//
//   req   start request (sampled by the unit only while not busy)
//   Op    operation code (000 NOP, 001 MULH, 010 MULHU, 011 MULW,
//         100 DIVW, 101 DIVWU, 110/111 NOP)
//   A, B  operands, bit 0 is the MSB
//   C     result (product half or quotient)
//   R     remainder (DIV ops), 0 for MUL ops
//   D     flags {OV, LT, GT, EQ}
//   cnt   iterations remaining in CALC, 0 otherwise
//   busy  high while the unit is computing
//   ack   one-cycle completion pulse
//
// Modports: master = requester (drives req/Op/A/B), slave = the unit.
// -----------------------------------------------------------------------------
interface iter_mdu_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
);
  logic               req;
  logic [2:0]         Op;
  logic [0:WIDTH-1]   A;
  logic [0:WIDTH-1]   B;
  logic [0:WIDTH-1]   C;
  logic [0:WIDTH-1]   R;
  logic [3:0]         D;
  logic [CNT_W-1:0]   cnt;
  logic               busy;
  logic               ack;

  modport master (
    output req, Op, A, B,
    input  C, R, D, cnt, busy, ack
  );

  modport slave (
    input  req, Op, A, B,
    output C, R, D, cnt, busy, ack
  );
endinterface

// File: rtl/iter_mdu.sv
// -----------------------------------------------------------------------------
// iter_mdu
// Iterative multiply/divide unit. One radix-2 step per cycle on operand
// magnitudes (shift-add multiply, restoring divide), then one FIX cycle that
// applies the sign correction and loads the registered C/R/D outputs.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   iter_mdu_if.slave (req/Op/A/B in; C/R/D/cnt/busy/ack out)
//
// Parameters:
//   WIDTH  operand/result width (even, >= 8)
//   CNT_W  width of cnt, 2**CNT_W > WIDTH
//
// Build option:
//   MDU_EARLY_OUT_EN  when defined, MUL ops leave CALC as soon as all remaining
//                     multiplier-magnitude bits are zero. Results are unchanged;
//                     DIV timing is unaffected.
// -----------------------------------------------------------------------------
module iter_mdu #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic       clk,
  input  logic       rst,
  iter_mdu_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_e;

  localparam logic [2:0] OP_MULH  = 3'b001;
  localparam logic [2:0] OP_MULHU = 3'b010;
  localparam logic [2:0] OP_MULW  = 3'b011;
  localparam logic [2:0] OP_DIVW  = 3'b100;
  localparam logic [2:0] OP_DIVWU = 3'b101;

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  // ---------------------------------------------------------------------------
  // Request decode (operands re-ordered to [MSB:0]; value is unchanged)
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic             w_in_valid;
  logic             w_in_signed;
  logic             w_in_div;
  logic             w_sign_a;
  logic             w_sign_b;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic             w_divz;
  logic             w_ovf;
  logic             w_accept;

  state_e r_state;
  state_e w_state_nxt;

  assign w_a         = bus.A;
  assign w_b         = bus.B;
  assign w_in_valid  = (bus.Op == OP_MULH) || (bus.Op == OP_MULHU) ||
                       (bus.Op == OP_MULW) || (bus.Op == OP_DIVW)  ||
                       (bus.Op == OP_DIVWU);
  assign w_in_signed = (bus.Op == OP_MULH) || (bus.Op == OP_MULW) ||
                       (bus.Op == OP_DIVW);
  assign w_in_div    = (bus.Op == OP_DIVW) || (bus.Op == OP_DIVWU);
  assign w_sign_a    = w_in_signed && w_a[WIDTH-1];
  assign w_sign_b    = w_in_signed && w_b[WIDTH-1];
  // Magnitude of the most-negative value is 2**(WIDTH-1), which is exact
  // when read as unsigned.
  assign w_mag_a     = w_sign_a ? (~w_a + 1'b1) : w_a;
  assign w_mag_b     = w_sign_b ? (~w_b + 1'b1) : w_b;
  assign w_divz      = w_in_div && (w_b == '0);
  assign w_ovf       = (bus.Op == OP_DIVW) && (w_a == MOST_NEG) && (w_b == '1);
  assign w_accept    = ((r_state == S_IDLE) || (r_state == S_DONE)) &&
                       bus.req && w_in_valid;

  // ---------------------------------------------------------------------------
  // Working registers
  // ---------------------------------------------------------------------------
  logic [2:0]         r_op;
  logic               r_sign_a;   // dividend sign, also the remainder sign
  logic               r_neg;      // operand signs differ
  logic               r_divz;
  logic               r_ovf;
  logic [2*WIDTH-1:0] r_acc;      // product accumulator
  logic [2*WIDTH-1:0] r_mcand;    // multiplicand, shifted left each step
  logic [WIDTH-1:0]   r_shf;      // MUL: multiplier (shifts right); DIV: dividend -> quotient
  logic [WIDTH-1:0]   r_rem;      // partial remainder (always < divisor between steps)
  logic [WIDTH-1:0]   r_dvsr;
  logic [CNT_W-1:0]   r_cnt;

  logic [WIDTH-1:0]   r_c;
  logic [WIDTH-1:0]   r_r;
  logic [3:0]         r_d;

  logic               w_is_div;
  logic               w_last;

  assign w_is_div = r_op[2];

`ifdef MDU_EARLY_OUT_EN
  // Exit once the multiplier bits still to be consumed are all zero.
  assign w_last = (r_cnt == '0) || (!w_is_div && (r_shf[WIDTH-1:1] == '0));
`else
  assign w_last = (r_cnt == '0);
`endif

  // ---------------------------------------------------------------------------
  // Restoring divide step: the WIDTH+1-bit shifted partial remainder is
  // compared with the divisor; on success the difference fits in WIDTH bits.
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]   w_rem_sh;
  logic             w_q_bit;
  logic [WIDTH-1:0] w_rem_sub;

  assign w_rem_sh  = {r_rem, r_shf[WIDTH-1]};
  assign w_q_bit   = (w_rem_sh >= {1'b0, r_dvsr});
  assign w_rem_sub = w_rem_sh[WIDTH-1:0] - r_dvsr;

  // ---------------------------------------------------------------------------
  // FIX: sign correction and result selection
  // ---------------------------------------------------------------------------
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem_s;
  logic [WIDTH-1:0]   w_c;
  logic [WIDTH-1:0]   w_r;
  logic               w_ov;
  logic [3:0]         w_d;

  // NOTE: every signal written in this block gets a default first, so no
  // path leaves one unassigned and no latch is inferred.
  always_comb begin
    w_prod  = r_neg    ? (~r_acc + 1'b1) : r_acc;
    w_quo   = r_neg    ? (~r_shf + 1'b1) : r_shf;
    w_rem_s = r_sign_a ? (~r_rem + 1'b1) : r_rem;
    w_c     = '0;
    w_r     = '0;
    w_ov    = 1'b0;
    case (r_op)
      OP_MULH, OP_MULHU: begin
        w_c = w_prod[2*WIDTH-1:WIDTH];
      end
      OP_MULW: begin
        w_c  = w_prod[WIDTH-1:0];
        w_ov = (w_prod[2*WIDTH-1:WIDTH] != {WIDTH{w_prod[WIDTH-1]}});
      end
      OP_DIVW, OP_DIVWU: begin
        // On divide by zero r_rem was loaded with |A|, so w_rem_s is A.
        w_r = w_rem_s;
        if (r_divz) begin
          w_c  = '0;
          w_ov = 1'b1;
        end else begin
          w_c  = w_quo;
          w_ov = r_ovf;
        end
      end
      default: ;
    endcase
    // Signed compare of C against zero.
    w_d = {w_ov, w_c[WIDTH-1], !w_c[WIDTH-1] && (w_c != '0), (w_c == '0)};
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = w_divz ? S_FIX : S_CALC;
      end
      S_CALC: begin
        if (w_last) w_state_nxt = S_FIX;
      end
      S_FIX: begin
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (w_accept) w_state_nxt = w_divz ? S_FIX : S_CALC;
        else          w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  // NOTE: only architecturally visible registers are reset; working registers
  // are always loaded on accept before they are read, so they need no reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_c   <= '0;
      r_r   <= '0;
      r_d   <= '0;
    end else begin
      if (w_accept) begin
        r_op     <= bus.Op;
        r_sign_a <= w_sign_a;
        r_neg    <= w_sign_a ^ w_sign_b;
        r_divz   <= w_divz;
        r_ovf    <= w_ovf;
        r_acc    <= '0;
        r_mcand  <= {{WIDTH{1'b0}}, w_mag_a};
        r_shf    <= w_in_div ? w_mag_a : w_mag_b;
        r_rem    <= w_divz ? w_mag_a : '0;
        r_dvsr   <= w_mag_b;
        r_cnt    <= w_divz ? '0 : CNT_W'(WIDTH - 1);
      end else if (r_state == S_CALC) begin
        if (w_is_div) begin
          r_shf <= {r_shf[WIDTH-2:0], w_q_bit};
          r_rem <= w_q_bit ? w_rem_sub : w_rem_sh[WIDTH-1:0];
        end else begin
          r_acc   <= r_acc + (r_shf[0] ? r_mcand : '0);
          r_mcand <= r_mcand << 1;
          r_shf   <= r_shf >> 1;
        end
        r_cnt <= w_last ? '0 : (r_cnt - CNT_W'(1));
      end

      if (r_state == S_FIX) begin
        r_c <= w_c;
        r_r <= w_r;
        r_d <= w_d;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.C    = r_c;
  assign bus.R    = r_r;
  assign bus.D    = r_d;
  assign bus.cnt  = r_cnt;
  assign bus.busy = (r_state == S_CALC) || (r_state == S_FIX);
  assign bus.ack  = (r_state == S_DONE);

endmodule

// File: tb/tb_iter_mdu.sv
// -----------------------------------------------------------------------------
// tb_iter_mdu
// Self-checking bench for iter_mdu (WIDTH=32): a table of directed vectors
// with hand-computed results and latencies, plus sequences for request-while-
// busy, mid-operation reset, NOP requests and back-to-back issue.
// -----------------------------------------------------------------------------
module tb_iter_mdu;
  localparam int WIDTH = 32;
  localparam int CNT_W = 6;

  localparam logic [2:0] NOP   = 3'b000;
  localparam logic [2:0] MULH  = 3'b001;
  localparam logic [2:0] MULHU = 3'b010;
  localparam logic [2:0] MULW  = 3'b011;
  localparam logic [2:0] DIVW  = 3'b100;
  localparam logic [2:0] DIVWU = 3'b101;

  typedef struct {
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] r;
    logic [3:0]       d;
  } vec_t;

  localparam int NVEC = 13;
  vec_t vecs [NVEC];

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  iter_mdu_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  iter_mdu #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Expected edges from the accepting edge to the edge after which ack is high.
  function automatic int exp_lat(input logic [2:0] op, input logic [WIDTH-1:0] b);
`ifdef MDU_EARLY_OUT_EN
    logic [WIDTH-1:0] m;
    int               n;
`endif
    if (op == DIVW || op == DIVWU) return (b == '0) ? 1 : WIDTH + 1;
`ifdef MDU_EARLY_OUT_EN
    m = (op != MULHU && b[WIDTH-1]) ? (~b + 1'b1) : b;
    n = 1;
    for (int i = 0; i < WIDTH; i++) if (m[i]) n = i + 1;
    return n + 1;
`else
    return WIDTH + 1;
`endif
  endfunction

  // Presents a request for one edge (the accepting edge k); returns at k+1ns.
  task automatic start(input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    bus.req = 1'b1;
    bus.Op  = op;
    bus.A   = a;
    bus.B   = b;
    @(posedge clk); #1;
    bus.req = 1'b0;
    bus.Op  = NOP;
  endtask

  // Counts edges until ack is seen (bounded).
  task automatic wait_ack(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!bus.ack && lat < 200);
  endtask

  task automatic count_acks(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (bus.ack) n++;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int               lat;
    int               nack;
    logic [WIDTH-1:0] tmp;

    vecs[0]  = '{op: MULW,  a: 32'hFFFFFFFD, b: 32'h00000007, c: 32'hFFFFFFEB, r: 32'h0,        d: 4'b0100};
    vecs[1]  = '{op: MULH,  a: 32'h80000000, b: 32'h80000000, c: 32'h40000000, r: 32'h0,        d: 4'b0010};
    vecs[2]  = '{op: MULHU, a: 32'h80000000, b: 32'h80000000, c: 32'h40000000, r: 32'h0,        d: 4'b0010};
    vecs[3]  = '{op: MULHU, a: 32'hFFFFFFFF, b: 32'hFFFFFFFF, c: 32'hFFFFFFFE, r: 32'h0,        d: 4'b0100};
    vecs[4]  = '{op: MULW,  a: 32'h00010000, b: 32'h00010000, c: 32'h00000000, r: 32'h0,        d: 4'b1001};
    vecs[5]  = '{op: MULH,  a: 32'hFFFFFFFF, b: 32'h00000002, c: 32'hFFFFFFFF, r: 32'h0,        d: 4'b0100};
    vecs[6]  = '{op: MULW,  a: 32'h00000003, b: 32'h00000005, c: 32'h0000000F, r: 32'h0,        d: 4'b0010};
    vecs[7]  = '{op: DIVW,  a: 32'hFFFFFFF9, b: 32'h00000002, c: 32'hFFFFFFFD, r: 32'hFFFFFFFF, d: 4'b0100};
    vecs[8]  = '{op: DIVWU, a: 32'h00000007, b: 32'h00000002, c: 32'h00000003, r: 32'h00000001, d: 4'b0010};
    vecs[9]  = '{op: DIVW,  a: 32'h80000000, b: 32'hFFFFFFFF, c: 32'h80000000, r: 32'h0,        d: 4'b1100};
    vecs[10] = '{op: DIVWU, a: 32'h00001234, b: 32'h00000000, c: 32'h00000000, r: 32'h00001234, d: 4'b1001};
    vecs[11] = '{op: DIVW,  a: 32'h00000007, b: 32'hFFFFFFFE, c: 32'hFFFFFFFD, r: 32'h00000001, d: 4'b0100};
    vecs[12] = '{op: DIVW,  a: 32'hFFFFFFFF, b: 32'h00000000, c: 32'h00000000, r: 32'hFFFFFFFF, d: 4'b1001};

    rst     = 1'b1;
    bus.req = 1'b0;
    bus.Op  = NOP;
    bus.A   = '0;
    bus.B   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset C",    bus.C,    0);
    check("reset R",    bus.R,    0);
    check("reset D",    bus.D,    0);
    check("reset cnt",  bus.cnt,  0);
    check("reset busy", bus.busy, 0);
    check("reset ack",  bus.ack,  0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Table-driven vectors
    for (int i = 0; i < NVEC; i++) begin
      start(vecs[i].op, vecs[i].a, vecs[i].b);
      check($sformatf("v%0d busy after accept", i), bus.busy, 1);
      check($sformatf("v%0d cnt after accept", i), bus.cnt,
            (vecs[i].op[2] && vecs[i].b == '0) ? 0 : WIDTH - 1);
      wait_ack(lat);
      check($sformatf("v%0d latency", i), lat, exp_lat(vecs[i].op, vecs[i].b));
      check($sformatf("v%0d C", i), bus.C, vecs[i].c);
      check($sformatf("v%0d R", i), bus.R, vecs[i].r);
      check($sformatf("v%0d D", i), bus.D, vecs[i].d);
      check($sformatf("v%0d busy in DONE", i), bus.busy, 0);
      @(posedge clk); #1;
      check($sformatf("v%0d ack one cycle", i), bus.ack, 0);
    end

    // NOP and reserved opcodes are ignored
    start(NOP, 32'h5, 32'h3);
    check("nop busy", bus.busy, 0);
    start(3'b111, 32'h5, 32'h3);
    check("op111 busy", bus.busy, 0);
    count_acks(5, nack);
    check("nop no ack", nack, 0);

    // Request while busy is ignored, result unchanged, outputs hold afterwards
    start(MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (2) @(posedge clk);
    #1;
    bus.req = 1'b1;
    bus.Op  = DIVWU;
    bus.A   = 32'd100;
    bus.B   = 32'd7;
    @(posedge clk); #1;
    bus.req = 1'b0;
    bus.Op  = NOP;
    wait_ack(lat);
    check("busy-req latency", lat + 3, exp_lat(MULHU, 32'hFFFFFFFF));
    check("busy-req C", bus.C, 32'hFFFFFFFE);
    check("busy-req R", bus.R, 0);
    repeat (3) @(posedge clk);
    #1;
    check("hold C", bus.C, 32'hFFFFFFFE);
    check("hold D", bus.D, 4'b0100);
    count_acks(40, nack);
    check("busy-req not queued", nack, 0);

    // Reset at edge k+5 aborts the operation
    start(DIVWU, 32'd7, 32'd2);
    repeat (3) @(posedge clk);
    #1;
    check("cnt at k+3", bus.cnt, WIDTH - 1 - 3);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort C",    bus.C,    0);
    check("abort R",    bus.R,    0);
    check("abort D",    bus.D,    0);
    check("abort cnt",  bus.cnt,  0);
    check("abort busy", bus.busy, 0);
    count_acks(40, nack);
    check("abort no ack", nack, 0);

    // Back-to-back: request held in the DONE cycle is accepted at the next edge
    start(MULW, 32'd3, 32'd5);
    wait_ack(lat);
    check("b2b first C", bus.C, 32'd15);
    bus.req = 1'b1;
    bus.Op  = DIVWU;
    bus.A   = 32'd100;
    bus.B   = 32'd7;
    @(posedge clk); #1;
    bus.req = 1'b0;
    bus.Op  = NOP;
    check("b2b busy", bus.busy, 1);
    check("b2b cnt",  bus.cnt,  WIDTH - 1);
    check("b2b ack low", bus.ack, 0);
    wait_ack(lat);
    check("b2b latency", lat, WIDTH + 1);
    check("b2b C", bus.C, 32'd14);
    check("b2b R", bus.R, 32'd2);
    check("b2b D", bus.D, 4'b0010);

    // Random-ish MULW cross-check against a simple model
    for (int i = 0; i < 4; i++) begin
      logic [63:0] p;
      bus.A = $urandom_range(0, 65535);
      bus.B = $urandom_range(0, 65535);
      tmp   = bus.B;
      p     = 64'(bus.A) * 64'(tmp);
      start(MULW, bus.A, tmp);
      wait_ack(lat);
      check($sformatf("mulw rnd%0d C", i), bus.C, p[31:0]);
      check($sformatf("mulw rnd%0d latency", i), lat, exp_lat(MULW, tmp));
      @(posedge clk); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
